// File: rtl/display_scan_scheduler.sv
// Eight-digit multiplexed 7-segment scan driver with a double-buffered display word.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 stays lit).
module display_scan_scheduler #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic [7:0]  blank_mask,
  output logic [7:0]  Anode_Activate,
  output logic [6:0]  LED_out,
  output logic [2:0]  digit_sel,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] prescaler_q, prescaler_d;
  logic [2:0]       digit_q, digit_d;
  logic [31:0]      display_q, display_d;
  logic [31:0]      pending_q, pending_d;
  logic             pending_full_q, pending_full_d;
  logic [7:0]       anode_q, anode_d;
  logic [6:0]       led_q, led_d;
  logic [2:0]       sel_q;
  logic             fdone_q;

  logic       tick, boundary, accept, blanked, lz_blank;
  logic [3:0] nibble;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'h01;  4'h1: seg = 7'h4F;  4'h2: seg = 7'h12;  4'h3: seg = 7'h06;
      4'h4: seg = 7'h4C;  4'h5: seg = 7'h24;  4'h6: seg = 7'h20;  4'h7: seg = 7'h0F;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h04;  4'hA: seg = 7'h08;  4'hB: seg = 7'h60;
      4'hC: seg = 7'h31;  4'hD: seg = 7'h42;  4'hE: seg = 7'h30;  default: seg = 7'h38;
    endcase
  endfunction

  assign wr_ready = ~pending_full_q & ~reset;
  assign tick     = (prescaler_q == LAST);
  assign boundary = tick && (digit_q == 3'd7);
  assign accept   = wr_valid && wr_ready;
  assign nibble   = display_q[{digit_q, 2'b00} +: 4];

  always_comb begin
    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lz_blank = (digit_q != 3'd0) && ((display_q >> {digit_q, 2'b00}) == 32'h0);
`endif
  end

  assign blanked = blank_mask[digit_q] | lz_blank;

  always_comb begin
    prescaler_d    = tick ? '0 : prescaler_q + CNT_W'(1);
    digit_d        = tick ? digit_q + 3'd1 : digit_q;
    display_d      = display_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    // Commit only what was pending before this edge; a same-cycle accept waits a frame.
    if (boundary && pending_full_q) begin
      display_d      = pending_q;
      pending_full_d = 1'b0;
    end
    if (accept) begin
      pending_d      = wr_data;
      pending_full_d = 1'b1;
    end
    anode_d = blanked ? 8'hFF : ~(8'd1 << digit_q);
    led_d   = blanked ? 7'h7F : seg(nibble);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      prescaler_q    <= '0;
      digit_q        <= 3'd0;
      display_q      <= 32'h0;
      pending_q      <= 32'h0;
      pending_full_q <= 1'b0;
      anode_q        <= 8'hFF;
      led_q          <= 7'h7F;
      sel_q          <= 3'd0;
      fdone_q        <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      digit_q        <= digit_d;
      display_q      <= display_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      anode_q        <= anode_d;
      led_q          <= led_d;
      sel_q          <= digit_q;
      fdone_q        <= boundary;
    end
  end

  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;
  assign digit_sel      = sel_q;
  assign frame_done     = fdone_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Randomized bench for display_scan_scheduler against a cycle-count reference model.
module tb_display_scan_scheduler;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        wr_ready;
  logic [7:0]  blank_mask = 8'h00;
  logic [7:0]  an;
  logic [6:0]  led;
  logic [2:0]  dsel;
  logic        fdone;

  display_scan_scheduler #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clock_100Mhz(clk), .reset(rst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .blank_mask(blank_mask), .Anode_Activate(an),
    .LED_out(led), .digit_sel(dsel), .frame_done(fdone)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  end

  // Reference: cycles since reset release determine slot, digit and frame edge.
  int          cyc = 0;
  logic [31:0] m_disp = 0, m_pend = 0;
  bit          m_full = 0, last_acc = 0;
  logic [7:0]  e_an;
  logic [6:0]  e_led;
  logic [2:0]  e_sel;
  bit          e_fd;

  task automatic step();
    int  dig;
    bit  bnd, blank;
    @(posedge clk);
    if (rst) begin
      cyc = 0; m_disp = 0; m_full = 0; last_acc = 0;
      e_an = 8'hFF; e_led = 7'h7F; e_sel = 0; e_fd = 0;
    end else begin
      dig   = (cyc / DIV) % 8;
      bnd   = (cyc % DIV == DIV - 1) && (dig == 7);
      blank = blank_mask[dig];
`ifdef LEADING_ZERO_BLANK_EN
      if (dig > 0 && (m_disp >> (4 * dig)) == 0) blank = 1;
`endif
      e_sel = 3'(dig);
      e_an  = 8'hFF;
      if (!blank) e_an[dig] = 1'b0;
      e_led = blank ? 7'h7F : seg_tab[(m_disp >> (4 * dig)) & 32'hF];
      e_fd  = bnd;
      last_acc = wr_valid && !m_full;
      if (bnd && m_full) begin m_disp = m_pend; m_full = 0; end
      if (last_acc) begin m_pend = wr_data; m_full = 1; end
      cyc++;
    end
    #1;
    chk("anode", 32'(an), 32'(e_an));
    chk("led", 32'(led), 32'(e_led));
    chk("digit_sel", 32'(dsel), 32'(e_sel));
    chk("frame_done", 32'(fdone), 32'(e_fd));
    chk("wr_ready", 32'(wr_ready), 32'(!m_full && !rst));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic put(input logic [31:0] d);
    int b = 0;
    wr_valid = 1; wr_data = d;
    do begin step(); b++; end while (!last_acc && b < 200);
    if (!last_acc) chk("put_timeout", 32'(b), 32'(0));
    wr_valid = 0;
  endtask

  initial begin
    // 1: reset then free-running scan
    run(3);
    rst = 0;
    step();
    chk("rel_anode", 32'(an), 32'h00FE);
    chk("rel_led", 32'(led), 32'h0001);
    run(70);
    // 2: mid-frame write
    put(32'h89ABCDEF);
    run(80);
    // 3: back-to-back writes, second stalls until first commits
    put(32'h11111111);
    put(32'h22222222);
    run(80);
    // 4: blank mask over lower digits
    blank_mask = 8'h0F;
    put(32'h12345678);
    run(100);
    blank_mask = 8'h00;
    // 5: reset during digit 5 with a pending word
    run(70);
    for (int i = 0; i < 64 && ((cyc / DIV) % 8) != 5; i++) step();
    put(32'hDEADBEEF);
    rst = 1;
    step();
    chk("rst_sel", 32'(dsel), 32'h0);
    rst = 0;
    run(70);
    // 6: leading-zero candidates (checked either way by the model)
    put(32'h000000A0);
    run(70);
    put(32'h0);
    run(70);
    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if (!(wr_valid && !last_acc)) begin
        wr_valid = ($urandom % 6) == 0;
        wr_data  = $urandom >> $urandom_range(0, 32);
      end
      if ($urandom % 50 == 0) blank_mask = 8'($urandom);
      if ($urandom % 16 == 0) blank_mask = 8'h00;
      rst = ($urandom % 400) == 0;
      step();
      rst = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
